// File: rtl/mux2_arbiter_pkg.sv
// Shared constants for the two-requester arbiter: state encoding and parameter defaults.
package mux2_arbiter_pkg;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned MAX_BURST_DEF = 4;

  localparam int unsigned ST_W  = 2;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_G0   = 2'b01;
  localparam logic [1:0] ST_G1   = 2'b10;

endpackage

// File: rtl/mux2_arbiter_mux2.sv
// Single-bit 2:1 mux cell: o_y = i_sel ? i_b : i_a.
module mux2_arbiter_mux2 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_sel,
  output logic o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mux2_arbiter.sv
// Two-requester arbiter with burst-limited fairness driving a shared 2:1 data mux.
module mux2_arbiter
  import mux2_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  output logic              ack0,
  output logic              ack1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              sel
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W:0]   MAX_EXT = (CNT_W + 1)'(MAX_BURST);

  logic [ST_W-1:0]   r_state;
  logic              r_last;
  logic              r_sel;
  logic [CNT_W-1:0]  r_cnt;

  logic [ST_W-1:0]   w_state_nxt;
  logic              w_last_nxt;
  logic              w_sel_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W:0]    w_cnt_inc;
  logic              w_own_id;
  logic              w_own_req;
  logic              w_oth_req;
  logic              w_xfer;
  logic [DATA_W-1:0] w_mux;

  // Granted-side view of the requests; the counter increment is one bit wider so it cannot wrap.
  assign w_own_id  = (r_state == ST_G1);
  assign w_own_req = w_own_id ? req1 : req0;
  assign w_oth_req = w_own_id ? req0 : req1;
  assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W + 1)'(1);

  // Handshake outputs; reset suppresses valid, ack and forces sel to 0.
  assign out_valid = !rst && (r_state != ST_IDLE) && w_own_req;
  assign w_xfer    = out_valid && out_ready;
  assign ack0      = w_xfer && (r_state == ST_G0);
  assign ack1      = w_xfer && (r_state == ST_G1);
  assign sel       = rst ? 1'b0 : r_sel;

  // Per-bit data mux; IDLE presents d0 regardless of the held select.
  for (genvar b = 0; b < int'(DATA_W); b++) begin : g_mux
    mux2_arbiter_mux2 u_mux (
      .i_a  (d0[b]),
      .i_b  (d1[b]),
      .i_sel(sel),
      .o_y  (w_mux[b])
    );
  end

  assign out_data = (r_state == ST_IDLE) ? d0 : w_mux;

  // State, select, burst counter and last-grant registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_sel   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: tie-break on last, burst-limited handover, hold while stalled.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (req0 && (!req1 || r_last)) begin
          w_state_nxt = ST_G0;
          w_sel_nxt   = 1'b0;
          w_cnt_nxt   = '0;
        end else if (req1) begin
          w_state_nxt = ST_G1;
          w_sel_nxt   = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      ST_G0, ST_G1: begin
        if (!w_own_req) begin
          w_last_nxt = w_own_id;
          if (w_oth_req) begin
            w_state_nxt = w_own_id ? ST_G0 : ST_G1;
            w_sel_nxt   = !w_own_id;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_xfer) begin
          if (w_oth_req) begin
            if (w_cnt_inc >= MAX_EXT) begin
              w_state_nxt = w_own_id ? ST_G0 : ST_G1;
              w_sel_nxt   = !w_own_id;
              w_last_nxt  = w_own_id;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
            end
          end else begin
            w_cnt_nxt = (w_cnt_inc >= MAX_EXT) ? MAX_CNT : w_cnt_inc[CNT_W-1:0];
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter: vector table plus stall, saturation and alternation sequences.
module tb_mux2_arbiter;

  logic       clk = 1'b0;
  logic       rst, req0, req1, out_ready;
  logic [7:0] d0, d1;
  logic       ack0, ack1, out_valid, sel;
  logic [7:0] out_data;
  logic       b_ack0, b_ack1, b_valid, b_sel;
  logic [7:0] b_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux2_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
    .ack0(ack0), .ack1(ack1), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sel(sel)
  );

  mux2_arbiter #(.DATA_W(8), .MAX_BURST(1)) dut_b1 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
    .ack0(b_ack0), .ack1(b_ack1), .out_valid(b_valid), .out_ready(out_ready),
    .out_data(b_data), .sel(b_sel)
  );

  typedef struct packed {
    logic       rst, r0, r1, rdy;
    logic [7:0] d0, d1;
    logic       ev, es, ea0, ea1;
    logic [7:0] ed;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic r, input logic a, input logic b, input logic y,
                              input logic [7:0] x0, input logic [7:0] x1,
                              input logic ev, input logic es, input logic e0, input logic e1,
                              input logic [7:0] ed);
    vec_t v;
    v.rst = r; v.r0 = a; v.r1 = b; v.rdy = y; v.d0 = x0; v.d1 = x1;
    v.ev = ev; v.es = es; v.ea0 = e0; v.ea1 = e1; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // {rst, req0, req1, rdy, d0, d1} -> {valid, sel, ack0, ack1, data}
    tbl[0]  = mk(1, 1, 1, 1, 8'hA5, 8'h5A, 0, 0, 0, 0, 8'hA5);
    tbl[1]  = mk(1, 1, 1, 1, 8'hA5, 8'h5A, 0, 0, 0, 0, 8'hA5);
    tbl[2]  = mk(0, 1, 1, 1, 8'hA5, 8'h5A, 0, 0, 0, 0, 8'hA5);
    tbl[3]  = mk(0, 1, 1, 1, 8'hA5, 8'h5A, 1, 0, 1, 0, 8'hA5);
    tbl[4]  = mk(0, 1, 1, 1, 8'hA5, 8'h5A, 1, 0, 1, 0, 8'hA5);
    tbl[5]  = mk(0, 1, 1, 1, 8'hA5, 8'h5A, 1, 0, 1, 0, 8'hA5);
    tbl[6]  = mk(0, 1, 1, 1, 8'hA5, 8'h5A, 1, 0, 1, 0, 8'hA5);
    tbl[7]  = mk(0, 1, 1, 1, 8'hA5, 8'h5A, 1, 1, 0, 1, 8'h5A);
    tbl[8]  = mk(0, 1, 1, 1, 8'hA5, 8'h5A, 1, 1, 0, 1, 8'h5A);
    tbl[9]  = mk(0, 1, 1, 1, 8'hA5, 8'h5A, 1, 1, 0, 1, 8'h5A);
    tbl[10] = mk(0, 1, 1, 1, 8'hA5, 8'h5A, 1, 1, 0, 1, 8'h5A);
    tbl[11] = mk(0, 1, 1, 1, 8'hA5, 8'h5A, 1, 0, 1, 0, 8'hA5);
    tbl[12] = mk(0, 0, 1, 1, 8'hA5, 8'h5A, 0, 0, 0, 0, 8'hA5);
    tbl[13] = mk(0, 0, 1, 1, 8'hA5, 8'h5A, 1, 1, 0, 1, 8'h5A);
    tbl[14] = mk(1, 0, 1, 1, 8'hA5, 8'h5A, 0, 0, 0, 0, 8'hA5);
    tbl[15] = mk(0, 0, 0, 1, 8'hA5, 8'h5A, 0, 0, 0, 0, 8'hA5);
    tbl[16] = mk(0, 0, 1, 1, 8'hA5, 8'h5A, 0, 0, 0, 0, 8'hA5);
    tbl[17] = mk(0, 0, 1, 0, 8'hA5, 8'h5A, 1, 1, 0, 0, 8'h5A);
    tbl[18] = mk(0, 0, 0, 1, 8'hA5, 8'h5A, 0, 1, 0, 0, 8'h5A);
    tbl[19] = mk(0, 0, 0, 1, 8'hA5, 8'h5A, 0, 1, 0, 0, 8'hA5);
    tbl[20] = mk(0, 1, 1, 1, 8'hA5, 8'h5A, 0, 1, 0, 0, 8'hA5);
    tbl[21] = mk(0, 1, 1, 1, 8'h3C, 8'hC3, 1, 0, 1, 0, 8'h3C);

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0; d0 = '0; d1 = '0;

    // Table: reset, tie-break, 4/4 bursts, withdrawal handover, reset on transfer, stall, IDLE hold.
    for (int i = 0; i < NV; i++) begin
      rst = tbl[i].rst; req0 = tbl[i].r0; req1 = tbl[i].r1; out_ready = tbl[i].rdy;
      d0 = tbl[i].d0; d1 = tbl[i].d1;
      #2;
      chk("vec_valid", i, 8'(out_valid), 8'(tbl[i].ev));
      chk("vec_sel",   i, 8'(sel),       8'(tbl[i].es));
      chk("vec_ack0",  i, 8'(ack0),      8'(tbl[i].ea0));
      chk("vec_ack1",  i, 8'(ack1),      8'(tbl[i].ea1));
      chk("vec_data",  i, out_data,      tbl[i].ed);
      @(posedge clk);
      #1;
    end

    // Stall in G1 for 5 cycles, then exactly one ack1 on release.
    d0 = 8'hA5; d1 = 8'h5A;
    do_reset();
    req1 = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_valid", k, 8'(out_valid), 8'h01);
      chk("stall_sel",   k, 8'(sel),       8'h01);
      chk("stall_data",  k, out_data,      8'h5A);
      chk("stall_ack1",  k, 8'(ack1),      8'h00);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("release_ack1", 0, 8'(ack1), 8'h01);
    tick();
    req1 = 1'b0;
    #1;
    chk("after_ack1", 0, 8'(ack1), 8'h00);
    tick();

    // Ten back-to-back ack0 with req1 low, then req1 forces a handover after one more word.
    do_reset();
    req0 = 1'b1; out_ready = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("solo_ack0", k, 8'(ack0), 8'h01);
      chk("solo_sel",  k, 8'(sel),  8'h00);
      tick();
    end
    req1 = 1'b1;
    #1;
    chk("sat_ack0", 0, 8'(ack0), 8'h01);
    tick();
    #1;
    chk("sat_sel",  0, 8'(sel),      8'h01);
    chk("sat_ack1", 0, 8'(ack1),     8'h01);
    chk("sat_data", 0, out_data,     8'h5A);
    tick();

    // Both always requesting: 4/4 bursts on MAX_BURST=4, strict alternation on MAX_BURST=1.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      logic es4, es1;
      es4 = 1'(((k / 4) % 2));
      es1 = 1'(k % 2);
      #1;
      chk("b4_ack0", k, 8'(ack0),  8'(!es4));
      chk("b4_ack1", k, 8'(ack1),  8'(es4));
      chk("b4_data", k, out_data,  es4 ? 8'h5A : 8'hA5);
      chk("b1_ack0", k, 8'(b_ack0), 8'(!es1));
      chk("b1_ack1", k, 8'(b_ack1), 8'(es1));
      chk("b1_data", k, b_data,    es1 ? 8'h5A : 8'hA5);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
